bit_serializer: RTL



---
 rtl/bit_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the serial sequence detector. Words are
//   taken over a valid/ready handshake into a one-word holding buffer, then
//   moved into a shift register that emits one bit per clock. The holding
//   buffer lets the next word wait while the current one shifts, so
//   consecutive words leave with no idle cycle between their bit streams.
//   A defined idle level is driven whenever nothing is being shifted, because
//   the detector samples its input on every cycle.
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  level on bit_out while not shifting
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   din        parallel word
//   din_valid  din holds a word to transfer
//   din_ready  holding buffer can accept a word (low while reset is high)
//   bit_out    serial data bit, or IDLE_BIT when not shifting
//   bit_valid  bit_out carries a data bit this cycle
//   word_done  high while the last bit of a word is on bit_out
//   busy       a word sits in the buffer or in the shifter
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Holding buffer (stage 0) and shifter (stage 1)
  logic [WIDTH-1:0] buf_p0;
  logic             buf_full_p0;
  logic [WIDTH-1:0] sh_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;

  logic accept;
  logic last_bit;
  logic load;

  // Advance the shifter by one bit towards the serial output end.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST != 0) begin
      r = {v[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Serial bit currently presented by the shifter.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    logic r;
    if (MSB_FIRST != 0) begin
      r = v[WIDTH-1];
    end else begin
      r = v[0];
    end
    return r;
  endfunction

  // The buffer can only be written while empty, so an accept and a load
  // never coincide. A load happens as soon as the shifter is idle or is
  // presenting its last bit, which keeps the bit stream gap-free.
  assign din_ready = !buf_full_p0 && !reset;
  assign accept    = din_valid && din_ready;
  assign last_bit  = vld_p1 && (cnt_p1 == LAST_CNT);
  assign load      = buf_full_p0 && (!vld_p1 || last_bit);

  // ---- stage 0: holding buffer ----
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_p0 <= din;
    end
  end

  // ---- stage 1: shift register ----
  always_ff @(posedge clk) begin
    if (load) begin
      sh_p1 <= buf_p0;
    end else if (vld_p1) begin
      sh_p1 <= shift_step(sh_p1);
    end
  end

  // Control: buffer occupancy, bit counter and shifter-active flag. A reload
  // on the last bit takes priority over dropping vld_p1, so back-to-back
  // words keep vld_p1 high continuously.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      if (accept) begin
        buf_full_p0 <= 1'b1;
      end
      if (load) begin
        buf_full_p0 <= 1'b0;
        vld_p1      <= 1'b1;
        cnt_p1      <= '0;
      end else if (vld_p1) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
        if (cnt_p1 == LAST_CNT) begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  // Outputs come from registers only
  assign bit_valid = vld_p1;
  assign bit_out   = vld_p1 ? head_bit(sh_p1) : IDLE_BIT;
  assign word_done = last_bit;
  assign busy      = vld_p1 || buf_full_p0;

endmodule
